// File: rtl/halfbridge_pwm_scheduler_if.sv
// Half-bridge PWM scheduler bus: run/fault control and configuration in,
// shared counter, edge tick numbers and status out.
interface halfbridge_pwm_scheduler_if #(
    parameter int bitwidth = 10
);
    logic                enable;
    logic                fault;
    logic                fault_clear;
    logic                update_strobe;
    logic [bitwidth-1:0] period;
    logic [bitwidth-1:0] duty;
    logic [bitwidth-1:0] deadtime;

    logic [bitwidth-1:0] counter_value;
    logic [bitwidth-1:0] tick_number_rising_edge_high;
    logic [bitwidth-1:0] tick_number_falling_edge_high;
    logic [bitwidth-1:0] tick_number_rising_edge_low;
    logic [bitwidth-1:0] tick_number_falling_edge_low;
    logic                pulse_reset;
    logic                period_start;
    logic                update_pending;
    logic                fault_active;

    modport master (
        output enable, fault, fault_clear, update_strobe, period, duty, deadtime,
        input  counter_value, tick_number_rising_edge_high, tick_number_falling_edge_high,
               tick_number_rising_edge_low, tick_number_falling_edge_low,
               pulse_reset, period_start, update_pending, fault_active
    );

    modport slave (
        input  enable, fault, fault_clear, update_strobe, period, duty, deadtime,
        output counter_value, tick_number_rising_edge_high, tick_number_falling_edge_high,
               tick_number_rising_edge_low, tick_number_falling_edge_low,
               pulse_reset, period_start, update_pending, fault_active
    );
endinterface

// File: rtl/halfbridge_pwm_scheduler.sv
// Half-bridge leg timing controller: shared period counter, double-buffered
// config, dead-time-aware edge ticks, and run/stop/fault sequencing.
module halfbridge_pwm_scheduler #(
    parameter int bitwidth = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    halfbridge_pwm_scheduler_if.slave   bus
);
    localparam int W1 = bitwidth + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING, S_FAULT} state_t;

    typedef struct packed {
        logic [bitwidth-1:0] rise_h;
        logic [bitwidth-1:0] fall_h;
        logic [bitwidth-1:0] rise_l;
        logic [bitwidth-1:0] fall_l;
    } ticks_t;

    // Duty is clamped so both dead bands fit; if they cannot, every edge
    // collapses onto the period end and both sides stay low.
    function automatic ticks_t calc_ticks(input logic [bitwidth-1:0] per,
                                          input logic [bitwidth-1:0] duty,
                                          input logic [bitwidth-1:0] dt);
        ticks_t           t;
        logic [W1-1:0]    per_w, duty_w, dt_w, two_dt, dmax, d;
        per_w  = {1'b0, per};
        duty_w = {1'b0, duty};
        dt_w   = {1'b0, dt};
        two_dt = {dt, 1'b0};
        if (two_dt >= per_w) begin
            t = '{rise_h: per, fall_h: per, rise_l: per, fall_l: per};
        end else begin
            dmax     = per_w - two_dt;
            d        = (duty_w < dmax) ? duty_w : dmax;
            t.rise_h = dt;
            t.fall_h = bitwidth'(dt_w + d);
            t.rise_l = bitwidth'(dt_w + d + dt_w);
            t.fall_l = per;
        end
        return t;
    endfunction

    state_t              state_q, state_d;
    logic [bitwidth-1:0] cnt_q, cnt_d;
    logic [bitwidth-1:0] pend_per_q, pend_per_d, pend_duty_q, pend_duty_d, pend_dt_q, pend_dt_d;
    logic [bitwidth-1:0] act_per_q, act_per_d, act_duty_q, act_duty_d, act_dt_q, act_dt_d;
    logic                upd_pend_q, upd_pend_d;
    ticks_t              ticks_q, ticks_d;
    logic                pulse_reset_q, pulse_reset_d;
    logic                period_start_q, period_start_d;
    logic                fault_active_q, fault_active_d;

    logic running, running_next, at_end, apply;

    assign running      = (state_q == S_RUN) || (state_q == S_STOPPING);
    assign running_next = (state_d == S_RUN) || (state_d == S_STOPPING);
    assign at_end       = running && (cnt_q >= act_per_q);
    assign apply        = upd_pend_q && ((state_q == S_IDLE) || at_end);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.enable) state_d = S_RUN;
            S_RUN:      if (!bus.enable) state_d = S_STOPPING;
            S_STOPPING: if (bus.enable) state_d = S_RUN;
                        else if (at_end) state_d = S_IDLE;
            S_FAULT:    if (bus.fault_clear) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (bus.fault) state_d = S_FAULT;
    end

    always_comb begin
        cnt_d = '0;
        if (running_next && running && !at_end) cnt_d = cnt_q + 1'b1;
        pulse_reset_d  = !running_next;
        period_start_d = running_next && (cnt_d == '0);
        fault_active_d = (state_d == S_FAULT);

        pend_per_d  = bus.update_strobe ? bus.period   : pend_per_q;
        pend_duty_d = bus.update_strobe ? bus.duty     : pend_duty_q;
        pend_dt_d   = bus.update_strobe ? bus.deadtime : pend_dt_q;
        act_per_d   = apply ? pend_per_q  : act_per_q;
        act_duty_d  = apply ? pend_duty_q : act_duty_q;
        act_dt_d    = apply ? pend_dt_q   : act_dt_q;
        // A strobe landing on the apply cycle stays pending for the next boundary.
        upd_pend_d  = bus.update_strobe ? 1'b1 : (apply ? 1'b0 : upd_pend_q);

        ticks_d = calc_ticks(act_per_d, act_duty_d, act_dt_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            pend_per_q     <= '0;
            pend_duty_q    <= '0;
            pend_dt_q      <= '0;
            act_per_q      <= '0;
            act_duty_q     <= '0;
            act_dt_q       <= '0;
            upd_pend_q     <= 1'b0;
            ticks_q        <= '0;
            pulse_reset_q  <= 1'b1;
            period_start_q <= 1'b0;
            fault_active_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            pend_per_q     <= pend_per_d;
            pend_duty_q    <= pend_duty_d;
            pend_dt_q      <= pend_dt_d;
            act_per_q      <= act_per_d;
            act_duty_q     <= act_duty_d;
            act_dt_q       <= act_dt_d;
            upd_pend_q     <= upd_pend_d;
            ticks_q        <= ticks_d;
            pulse_reset_q  <= pulse_reset_d;
            period_start_q <= period_start_d;
            fault_active_q <= fault_active_d;
        end
    end

    assign bus.counter_value                 = cnt_q;
    assign bus.tick_number_rising_edge_high  = ticks_q.rise_h;
    assign bus.tick_number_falling_edge_high = ticks_q.fall_h;
    assign bus.tick_number_rising_edge_low   = ticks_q.rise_l;
    assign bus.tick_number_falling_edge_low  = ticks_q.fall_l;
    assign bus.pulse_reset                   = pulse_reset_q;
    assign bus.period_start                  = period_start_q;
    assign bus.update_pending                = upd_pend_q;
    assign bus.fault_active                  = fault_active_q;
endmodule

// File: doc/halfbridge_pwm_scheduler.md
Name: halfbridge_pwm_scheduler

Overview:
- Timing controller for one half-bridge leg built from two pulse generators (high side, low side).
- Owns the shared period counter and computes both pulses' rising/falling tick numbers from duty and dead-time settings.
- Double-buffers configuration so changes apply only at period boundaries.
- Sequences start, graceful stop and fault shutdown, and drives the pulse generators' reset.

Parameters:
bitwidth, 10, width of counter, period, duty, dead-time and tick-number buses

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  level; request to run PWM
fault  input  1  level; external fault, highest priority
fault_clear  input  1  single-cycle pulse; leaves FAULT
update_strobe  input  1  single-cycle pulse; captures config inputs into pending registers
period  input  bitwidth  last counter value of a period (counter runs 0..period)
duty  input  bitwidth  requested high-side on-time in ticks
deadtime  input  bitwidth  dead ticks before each edge
counter_value  output  bitwidth  shared counter to both pulse generators
tick_number_rising_edge_high  output  bitwidth  high-side rise tick
tick_number_falling_edge_high  output  bitwidth  high-side fall tick
tick_number_rising_edge_low  output  bitwidth  low-side rise tick
tick_number_falling_edge_low  output  bitwidth  low-side fall tick
pulse_reset  output  1  active-high reset to both pulse generators
period_start  output  1  one-cycle flag when counter_value==0 in RUN/STOPPING
update_pending  output  1  pending config not yet applied
fault_active  output  1  high in FAULT

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; counter_value=0; all tick outputs=0.
  - pulse_reset=1; period_start=0; update_pending=0; fault_active=0.
  - Active and pending config registers=0.
- All outputs are registered.
- States: IDLE, RUN, STOPPING, FAULT.
- fault==1 in any state: next state FAULT.
- IDLE:
  - counter held 0; pulse_reset=1.
  - A pending update is copied to active immediately (next cycle); update_pending clears.
  - enable==1 and fault==0: next cycle RUN, with counter_value=0 and pulse_reset=0.
- RUN:
  - counter increments by 1 per clock; after reaching period it wraps to 0.
  - period==0: counter stays 0.
  - enable==0: next state STOPPING.
- STOPPING:
  - Counter continues to the end of the period. On the cycle counter_value==period, next state IDLE.
  - enable returning to 1 before then: back to RUN, no glitch.
- FAULT:
  - Entered the cycle after fault==1: pulse_reset=1, counter=0, fault_active=1.
  - Exits to IDLE only when fault==0 and fault_clear==1 in the same cycle. fault_clear while fault==1 is ignored.
- Config update:
  - update_strobe captures period/duty/deadtime into pending registers and sets update_pending.
  - In RUN/STOPPING, pending is copied to active on the cycle counter_value==period, so the new values take effect from counter 0.
  - A strobe on that same cycle is captured into pending only; it applies at the next boundary.
  - A newer strobe overwrites an older unapplied one.
- Tick arithmetic (from active config, computed in bitwidth+1 bits, registered; visible the cycle after active changes):
  - dmax = period - 2*deadtime if 2*deadtime < period, else 0.
  - d = min(duty, dmax).
  - rise_high = deadtime; fall_high = deadtime + d; rise_low = fall_high + deadtime; fall_low = period.
  - If 2*deadtime >= period: rise_high = fall_high = rise_low = fall_low = period, so both outputs stay low.
  - rise==fall on one side means no pulse on that side (the pulse generator's falling condition wins).
- Invariants:
  - High and low windows never overlap.
  - Each window is separated by at least deadtime ticks within a period.

Test Plan:
- Basic timing: reset, period=99, duty=40, deadtime=5, strobe, enable=1 -> ticks 5/45/50/99; counter 0..99 wraps; period_start every 100 cycles.
- Duty clamp: period=99, deadtime=5, duty=95 -> fall_high=94, rise_low=fall_low=99 (no low pulse). With deadtime=50 -> all four ticks=99.
- Boundary update: in RUN at counter=30, strobe duty=20 -> old ticks held through counter=99; update_pending drops; new fall_high=25 from counter 0. A strobe at counter=99 applies one period later.
- Graceful stop: drop enable at counter=60 -> STOPPING, counter reaches 99, then IDLE with pulse_reset=1. Re-raise enable at 70 in a second run -> stays running.
- Fault: fault=1 at counter=20 -> next cycle pulse_reset=1, counter=0, fault_active=1. fault_clear while fault=1 -> ignored. fault=0 with fault_clear -> IDLE; enable restarts at counter 0.
- Async reset mid-RUN: assert reset=0 between clock edges -> outputs reach reset values immediately, with no clock edge needed.
